// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
// rx_entry_t is the word stored per received character.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int FIFO_DEPTH  = 16;
  localparam int RTS_MARGIN_DEFAULT = 2;

  typedef struct packed {
    logic                   perr;
    logic [UART_DATA_W-1:0] data;
  } rx_entry_t;

  typedef enum logic {
    RTS_SEND = 1'b0,
    RTS_HOLD = 1'b1
  } rts_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x rx_entry_t register array: one synchronous write port and a
// combinational read port addressed by the FIFO read pointer.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter  int DEPTH = FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  rx_entry_t       wdata,
  input  logic [AW-1:0]   raddr,
  output rx_entry_t       rdata
);

  rx_entry_t mem [DEPTH];

  // NOTE: the array has no reset; the level counter guarantees that no entry is
  // ever presented before it has been written, so resetting it buys nothing.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between uart_rx and the register block: first-word-fall-through
// head, fill level, threshold flag, sticky overrun and RTS hysteresis.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH      = FIFO_DEPTH,
  parameter  int DATA_W     = UART_DATA_W,
  parameter  int RTS_MARGIN = RTS_MARGIN_DEFAULT,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_perr_i,
  input  logic              rd_en_i,
  input  logic              flush_i,
  input  logic [AW:0]       thresh_i,
  input  logic              ovr_clr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_perr_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [AW:0]       level_o,
  output logic              thresh_hit_o,
  output logic              overrun_o,
  output logic              rts_n_o
);

  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_HOLD = (AW+1)'(DEPTH - RTS_MARGIN);
  localparam logic [AW:0] LVL_SEND = (AW+1)'(DEPTH / 2);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic [AW:0]   level_next;
  logic          overrun;
  logic          push;
  logic          pop;
  logic          we;
  logic          drop;
  rx_entry_t     wentry;
  rx_entry_t     head;
  rts_state_t    rts_state;
  rts_state_t    rts_next;

  assign full_o  = (level == LVL_FULL);
  assign empty_o = (level == '0);

  // A pop on a full FIFO frees the slot the coincident push writes into.
  assign push = wr_valid_i && (!full_o || rd_en_i);
  assign pop  = rd_en_i && !empty_o;
  assign we   = push && !flush_i;
  assign drop = wr_valid_i && full_o && !rd_en_i && !flush_i;

  assign wentry.perr = wr_perr_i;
  assign wentry.data = wr_data_i;

  uart_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (wentry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // NOTE: every signal written in an always_comb gets a default first so that
  // no path leaves it unassigned and infers a latch.
  always_comb begin
    level_next = level;
    if (flush_i) begin
      level_next = '0;
    end else if (push && !pop) begin
      level_next = level + LVL_ONE;
    end else if (pop && !push) begin
      level_next = level - LVL_ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      level <= level_next;
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (ovr_clr_i) begin
      overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rts_state <= RTS_SEND;
    end else begin
      rts_state <= rts_next;
    end
  end

  always_comb begin
    rts_next = rts_state;
    if (flush_i) begin
      rts_next = RTS_SEND;
    end else if (rts_state == RTS_SEND) begin
      if (level_next >= LVL_HOLD) rts_next = RTS_HOLD;
    end else begin
      if (level_next <= LVL_SEND) rts_next = RTS_SEND;
    end
  end

  // rts_n_o decodes a single state flop, so it cannot glitch.
  always_comb begin
    rts_n_o = (rts_state == RTS_HOLD);
  end

  always_comb begin
    rd_data_o = '0;
    rd_perr_o = 1'b0;
    if (!empty_o) begin
      rd_data_o = head.data;
      rd_perr_o = head.perr;
    end
  end

  assign level_o      = level;
  assign overrun_o    = overrun;
  assign thresh_hit_o = (thresh_i != '0) && (level >= thresh_i);

endmodule
